// File: rtl/input_unit.sv
// -----------------------------------------------------------------------------
// input_unit
//
// CU-facing input peripheral. The host pushes DW-bit values through a
// valid/ready port into a circular FIFO. The CU pulls them one at a time with a
// four-phase req/ack handshake. An empty FIFO stalls the CU by withholding
// in_ack until a value becomes available.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   rst_b       synchronous, active-high reset
//   in_req      request from the CU
//   in_data     value delivered to the CU; valid while in_ack=1
//   in_ack      acknowledge to the CU (registered)
//   host_valid  host offers host_data
//   host_data   value to enqueue
//   host_ready  combinational !fifo_full
//   fifo_count  number of stored entries, 0..2**AW
//   fifo_empty  fifo_count == 0
//   fifo_full   fifo_count == 2**AW
//
// Build option:
//   INPUT_UNIT_TRACE_EN  when defined, prints each value delivered to the CU
//                        and each push attempted while the FIFO is full.
//                        Cycle behaviour is identical either way.
// -----------------------------------------------------------------------------
module input_unit #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          in_req,
    output logic [DW-1:0] in_data,
    output logic          in_ack,
    input  logic          host_valid,
    input  logic [DW-1:0] host_data,
    output logic          host_ready,
    output logic [AW:0]   fifo_count,
    output logic          fifo_empty,
    output logic          fifo_full
);

    localparam int DEPTH = 2 ** AW;

    localparam logic [AW:0]   COUNT_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1'b1);
    localparam logic [AW:0]   COUNT_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_DATA = 2'd1;
    localparam logic [1:0] ST_ACK       = 2'd2;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [1:0]    state_r;
    logic          push_s;
    logic          pop_s;

    assign fifo_count = count_r;
    assign fifo_empty = (count_r == COUNT_ZERO);
    assign fifo_full  = (count_r == COUNT_FULL);
    assign host_ready = ~fifo_full;

    // A pop happens only on the edge that moves WAIT_DATA into ACK, so each
    // completed handshake consumes exactly one entry.
    assign push_s = host_valid & host_ready;
    assign pop_s  = (state_r == ST_WAIT_DATA) & in_req & (count_r != COUNT_ZERO);

    // FIFO storage write; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (push_s && !rst_b) begin
            mem_r[wr_ptr_r] <= host_data;
        end
    end

    // FIFO pointers and occupancy; AW-bit pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= COUNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Handshake FSM with registered in_ack / in_data.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_r <= ST_IDLE;
            in_ack  <= 1'b0;
            in_data <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    in_ack <= 1'b0;
                    if (in_req) begin
                        state_r <= ST_WAIT_DATA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_DATA: begin
                    if (!in_req) begin
                        // CU withdrew its request before data arrived.
                        state_r <= ST_IDLE;
                    end else if (count_r != COUNT_ZERO) begin
                        in_data <= mem_r[rd_ptr_r];
                        in_ack  <= 1'b1;
                        state_r <= ST_ACK;
                    end else begin
                        state_r <= ST_WAIT_DATA;
                    end
                end
                ST_ACK: begin
                    // in_data and in_ack hold until the CU drops its request.
                    if (!in_req) begin
                        in_ack  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ACK;
                    end
                end
                default: begin
                    in_ack  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef INPUT_UNIT_TRACE_EN
    // Trace of delivered values and dropped pushes.
    always @(posedge clk) begin
        if (!rst_b) begin
            if (pop_s) begin
                $display("[INPUT_UNIT] IN> %0d", mem_r[rd_ptr_r]);
            end
            if (host_valid && fifo_full) begin
                $display("[INPUT_UNIT] FULL, drop");
            end
        end
    end
`else
`endif

endmodule
